// File: rtl/dbg_req_scheduler.sv
// dbg_req_scheduler: issues per-hart debug_req pulses at programmed cycle
// offsets after run start, snoops the data-memory write port for the
// completion flag and result word, and runs a timeout watchdog.
// Optional feature macro: DBG_SCHED_REPEAT_EN adds cfg_period_i so that a slot
// re-arms with delay+=period after each pulse (period 0 = one-shot).

// One config slot: holds delay/period, fires a PULSE_CYCLES-long request.
module dbg_req_slot #(
  parameter int CNT_W        = 16,
  parameter int PULSE_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] delay_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] cycle_i,
  output logic             req_o
);
  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  logic             armed;
  logic [CNT_W-1:0] delay;
  logic [CNT_W-1:0] period;
  logic [PW-1:0]    cnt;
  logic [CNT_W:0]   next_delay;

  // Carry bit flags a re-arm offset that no longer fits the counter.
  assign next_delay = {1'b0, delay} + {1'b0, period};

  // Slot state: write, trigger on delay match, count pulse, re-arm or disarm.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      armed  <= 1'b0;
      delay  <= '0;
      period <= '0;
      cnt    <= '0;
      req_o  <= 1'b0;
    end else begin
      if (wr_i) begin
        armed  <= 1'b1;
        delay  <= delay_i;
        period <= period_i;
      end
      if (!run_i) begin
        // Leaving RUN (done/timeout/abort) truncates any pulse immediately.
        req_o <= 1'b0;
      end else if (req_o) begin
        if (cnt == '0) begin
          req_o <= 1'b0;
          if (period != '0 && !next_delay[CNT_W]) delay <= next_delay[CNT_W-1:0];
          else                                     armed <= 1'b0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end else if (armed && cycle_i == delay) begin
        req_o <= 1'b1;
        cnt   <= PW'(PULSE_CYCLES - 1);
      end
    end
  end
endmodule

module dbg_req_scheduler #(
  parameter int          NUM_HARTS    = 2,
  parameter int          CNT_W        = 16,
  parameter int          DATA_W       = 32,
  parameter int          PULSE_CYCLES = 1,
  parameter logic [31:0] FLAG_ADDR    = 32'h0000_0000,
  parameter logic [31:0] RESULT_ADDR  = 32'h0000_0004,
  localparam int         HW           = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 cfg_valid_i,
  input  logic [HW-1:0]        cfg_hart_i,
  input  logic [CNT_W-1:0]     cfg_delay_i,
`ifdef DBG_SCHED_REPEAT_EN
  input  logic [CNT_W-1:0]     cfg_period_i,
`endif
  output logic                 cfg_ready_o,
  input  logic [CNT_W-1:0]     timeout_i,
  input  logic                 mem_we_i,
  input  logic [31:0]          mem_addr_i,
  input  logic [DATA_W-1:0]    mem_wdata_i,
  output logic [NUM_HARTS-1:0] debug_req_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic [DATA_W-1:0]    result_o,
  output logic [CNT_W-1:0]     cycle_o
);
  typedef enum logic [2:0] {IDLE, ARMED, RUN, DONE, TIMEOUT} state_t;

  localparam logic [31:0] WORD_MASK = ~32'h3;

  state_t           state;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] tmo_lim;
  logic             hart_ok, cfg_wr, flag_hit, res_hit, tmo_hit, run_stay, slot_clr;

`ifdef DBG_SCHED_REPEAT_EN
  assign period = cfg_period_i;
`else
  assign period = '0;
`endif

  assign hart_ok  = (int'(cfg_hart_i) < NUM_HARTS);
  assign cfg_wr   = cfg_valid_i && cfg_ready_o && hart_ok;
  // Word-granular address match: byte offset bits are masked off.
  assign flag_hit = (state == RUN) && mem_we_i && (mem_wdata_i != '0) &&
                    ((mem_addr_i & WORD_MASK) == (FLAG_ADDR & WORD_MASK));
  assign res_hit  = (state == RUN) && mem_we_i &&
                    ((mem_addr_i & WORD_MASK) == (RESULT_ADDR & WORD_MASK));
  assign tmo_lim  = timeout_i - 1'b1;
  assign tmo_hit  = (state == RUN) && (timeout_i != '0) && (cycle_o == tmo_lim);
  // Slots may only trigger/continue while RUN persists into the next cycle.
  assign run_stay = (state == RUN) && start_i && !flag_hit && !tmo_hit;
  // Any return to IDLE wipes the slots.
  assign slot_clr = (state == RUN || state == DONE || state == TIMEOUT) && !start_i;

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_slot
    dbg_req_slot #(.CNT_W(CNT_W), .PULSE_CYCLES(PULSE_CYCLES)) u_slot (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clr_i    (slot_clr),
      .wr_i     (cfg_wr && (int'(cfg_hart_i) == h)),
      .delay_i  (cfg_delay_i),
      .period_i (period),
      .run_i    (run_stay),
      .cycle_i  (cycle_o),
      .req_o    (debug_req_o[h])
    );
  end

  // Control FSM with registered status outputs, cycle counter and result latch.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cfg_ready_o <= 1'b1;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
      result_o    <= '0;
      cycle_o     <= '0;
    end else begin
      case (state)
        IDLE, ARMED: begin
          if (start_i) begin
            state       <= RUN;
            busy_o      <= 1'b1;
            cfg_ready_o <= 1'b0;
            cycle_o     <= '0;
            result_o    <= '0;
          end else if (cfg_wr) begin
            state <= ARMED;
          end
        end
        RUN: begin
          if (res_hit) result_o <= mem_wdata_i;
          if (!start_i) begin
            state       <= IDLE;
            busy_o      <= 1'b0;
            cfg_ready_o <= 1'b1;
          end else if (flag_hit) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else if (tmo_hit) begin
            state     <= TIMEOUT;
            busy_o    <= 1'b0;
            timeout_o <= 1'b1;
          end else if (cycle_o != '1) begin
            cycle_o <= cycle_o + 1'b1;
          end
        end
        DONE, TIMEOUT: begin
          if (!start_i) begin
            state       <= IDLE;
            done_o      <= 1'b0;
            timeout_o   <= 1'b0;
            cfg_ready_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dbg_req_scheduler.sv
// Scoreboard bench for dbg_req_scheduler: per-cycle expected status is queued
// when a run is programmed and popped against the DUT each RUN cycle.
// DBG_SCHED_REPEAT_EN enables the periodic re-arm scenario.
module tb_dbg_req_scheduler;
  localparam int PULSE = 4;

  typedef struct packed {
    logic [1:0]  req;
    logic        busy;
    logic        done;
    logic        tmo;
    logic [15:0] cyc;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n, start, cfg_valid, cfg_ready, mem_we;
  logic [0:0]  cfg_hart;
  logic [15:0] cfg_delay, cfg_period, timeout, cycle;
  logic [31:0] mem_addr, mem_wdata, result;
  logic [1:0]  debug_req;
  logic        busy, done, tmo;

  int   checks = 0;
  int   failures = 0;
  obs_t sb[$];

  dbg_req_scheduler #(.NUM_HARTS(2), .CNT_W(16), .DATA_W(32), .PULSE_CYCLES(PULSE)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .cfg_valid_i (cfg_valid),
    .cfg_hart_i  (cfg_hart),
    .cfg_delay_i (cfg_delay),
`ifdef DBG_SCHED_REPEAT_EN
    .cfg_period_i(cfg_period),
`endif
    .cfg_ready_o (cfg_ready),
    .timeout_i   (timeout),
    .mem_we_i    (mem_we),
    .mem_addr_i  (mem_addr),
    .mem_wdata_i (mem_wdata),
    .debug_req_o (debug_req),
    .busy_o      (busy),
    .done_o      (done),
    .timeout_o   (tmo),
    .result_o    (result),
    .cycle_o     (cycle)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t obs();
    return {debug_req, busy, done, tmo, cycle};
  endfunction

  // Pulse window model: first pulse occupies cycles d+1 .. d+PULSE, repeats every per.
  function automatic logic hit(int k, int d, int per, int last);
    int s = d + 1;
    if (k > last) return 1'b0;
    while (s <= k) begin
      if (k < s + PULSE) return 1'b1;
      if (per == 0) return 1'b0;
      s += per;
    end
    return 1'b0;
  endfunction

  // Queue expected status for RUN cycles 0..n-1; last = final RUN cycle.
  task automatic push_run(int n, int last, bit a0, int d0, int p0, bit a1, int d1, int p1,
                          bit dn, bit to);
    obs_t e;
    for (int k = 0; k < n; k++) begin
      e.req  = {a1 && hit(k, d1, p1, last), a0 && hit(k, d0, p0, last)};
      e.busy = (k <= last);
      e.done = (k > last) && dn;
      e.tmo  = (k > last) && to;
      e.cyc  = 16'((k <= last) ? k : last);
      sb.push_back(e);
    end
  endtask

  task automatic cfg(int h, int d, int p);
    cfg_valid  = 1'b1;
    cfg_hart   = 1'(h);
    cfg_delay  = 16'(d);
    cfg_period = 16'(p);
    step();
    cfg_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (debug_req !== 2'b00) begin failures++; $display("FAIL reset_req got=%b exp=00", debug_req); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
    checks++; if ({busy, done, tmo} !== 3'b000) begin failures++; $display("FAIL reset_status got=%b exp=000", {busy, done, tmo}); end
    checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", result); end
    checks++; if (cycle !== 16'h0) begin failures++; $display("FAIL reset_cycle got=%0d exp=0", cycle); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    obs_t e, o;
    timeout = 16'd0;
    cfg(0, 19, 0);
    checks++; if ({cfg_ready, busy} !== 2'b10) begin failures++; $display("FAIL single_armed got=%b exp=10", {cfg_ready, busy}); end
    push_run(66, 60, 1, 19, 0, 0, 0, 0, 1, 0);
    start = 1'b1;
    step();
    for (int k = 0; k < 66; k++) begin
      e = sb.pop_front();
      o = obs();
      checks++; if (o !== e) begin failures++; $display("FAIL single k=%0d got=%h exp=%h", k, o, e); end
      mem_we    = (k == 30) || (k == 60);
      mem_addr  = 32'h0;
      mem_wdata = (k == 60) ? 32'h1 : 32'h0;
      step();
    end
    mem_we = 1'b0;
    start  = 1'b0;
    step();
    checks++; if ({busy, done, tmo, cfg_ready} !== 4'b0001) begin failures++; $display("FAIL single_idle got=%b exp=0001", {busy, done, tmo, cfg_ready}); end
    checks++; if (cycle !== 16'd60) begin failures++; $display("FAIL single_cycle_kept got=%0d exp=60", cycle); end
  endtask

  task automatic test_two_harts();
    obs_t e, o;
    timeout = 16'd0;
    cfg(0, 5, 0);
    cfg(1, 5, 0);
    push_run(20, 15, 1, 5, 0, 1, 5, 0, 1, 0);
    start = 1'b1;
    step();
    for (int k = 0; k < 20; k++) begin
      e = sb.pop_front();
      o = obs();
      checks++; if (o !== e) begin failures++; $display("FAIL two_harts k=%0d got=%h exp=%h", k, o, e); end
      mem_we    = (k == 12) || (k == 15);
      mem_addr  = (k == 12) ? 32'h7 : 32'h2;
      mem_wdata = (k == 12) ? 32'h37 : 32'h1;
      step();
    end
    mem_we = 1'b0;
    checks++; if (result !== 32'h37) begin failures++; $display("FAIL two_harts_result got=%h exp=37", result); end
    start = 1'b0;
    step();
    checks++; if (result !== 32'h37) begin failures++; $display("FAIL two_harts_result_kept got=%h exp=37", result); end
  endtask

  task automatic test_timeout();
    obs_t e, o;
    timeout = 16'd100;
    push_run(105, 99, 0, 0, 0, 0, 0, 0, 0, 1);
    start = 1'b1;
    step();
    for (int k = 0; k < 105; k++) begin
      e = sb.pop_front();
      o = obs();
      checks++; if (o !== e) begin failures++; $display("FAIL timeout k=%0d got=%h exp=%h", k, o, e); end
      step();
    end
    start = 1'b0;
    step();
    checks++; if ({tmo, cycle} !== {1'b0, 16'd99}) begin failures++; $display("FAIL timeout_clear got=%b/%0d exp=0/99", tmo, cycle); end
  endtask

  task automatic test_collision();
    obs_t e, o;
    timeout = 16'd100;
    push_run(102, 99, 0, 0, 0, 0, 0, 0, 1, 0);
    start = 1'b1;
    step();
    for (int k = 0; k < 102; k++) begin
      e = sb.pop_front();
      o = obs();
      checks++; if (o !== e) begin failures++; $display("FAIL collide_tmo k=%0d got=%h exp=%h", k, o, e); end
      mem_we = (k == 99); mem_addr = 32'h0; mem_wdata = 32'h5;
      step();
    end
    mem_we = 1'b0;
    start  = 1'b0;
    step();
    timeout = 16'd0;
    cfg(0, 37, 0);
    push_run(45, 40, 1, 37, 0, 0, 0, 0, 1, 0);
    start = 1'b1;
    step();
    for (int k = 0; k < 45; k++) begin
      e = sb.pop_front();
      o = obs();
      checks++; if (o !== e) begin failures++; $display("FAIL collide_pulse k=%0d got=%h exp=%h", k, o, e); end
      mem_we = (k == 40); mem_addr = 32'h0; mem_wdata = 32'h1;
      step();
    end
    mem_we = 1'b0;
    start  = 1'b0;
    step();
  endtask

  task automatic test_reset_abort();
    obs_t e, o;
    timeout = 16'd0;
    cfg(0, 10, 0);
    push_run(13, 1000, 1, 10, 0, 0, 0, 0, 0, 0);
    start = 1'b1;
    step();
    for (int k = 0; k < 13; k++) begin
      e = sb.pop_front();
      o = obs();
      checks++; if (o !== e) begin failures++; $display("FAIL rst_run k=%0d got=%h exp=%h", k, o, e); end
      step();
    end
    checks++; if (debug_req !== 2'b01) begin failures++; $display("FAIL rst_midpulse got=%b exp=01", debug_req); end
    rst_n = 1'b0;
    start = 1'b0;
    step();
    checks++; if ({debug_req, busy, done, tmo, cfg_ready} !== 6'b000001) begin failures++; $display("FAIL rst_outputs got=%b exp=000001", {debug_req, busy, done, tmo, cfg_ready}); end
    rst_n = 1'b1;
    step();
    // Slot 0 must be disarmed; a config attempted mid-RUN must not arm slot 1.
    push_run(16, 1000, 0, 0, 0, 0, 0, 0, 0, 0);
    start = 1'b1;
    step();
    for (int k = 0; k < 16; k++) begin
      e = sb.pop_front();
      o = obs();
      checks++; if (o !== e) begin failures++; $display("FAIL abort_run k=%0d got=%h exp=%h", k, o, e); end
      if (k == 2) begin
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL run_cfg_ready got=%b exp=0", cfg_ready); end
      end
      cfg_valid = (k == 2); cfg_hart = 1'b1; cfg_delay = 16'd3;
      step();
    end
    cfg_valid = 1'b0;
    start     = 1'b0;
    step();
    checks++; if ({busy, done, tmo, cfg_ready} !== 4'b0001) begin failures++; $display("FAIL abort_status got=%b exp=0001", {busy, done, tmo, cfg_ready}); end
  endtask

`ifdef DBG_SCHED_REPEAT_EN
  task automatic test_repeat();
    obs_t e, o;
    timeout = 16'd0;
    cfg(0, 10, 10);
    cfg(1, 10, 0);
    push_run(50, 45, 1, 10, 10, 1, 10, 0, 1, 0);
    start = 1'b1;
    step();
    for (int k = 0; k < 50; k++) begin
      e = sb.pop_front();
      o = obs();
      checks++; if (o !== e) begin failures++; $display("FAIL repeat k=%0d got=%h exp=%h", k, o, e); end
      mem_we = (k == 45); mem_addr = 32'h0; mem_wdata = 32'h1;
      step();
    end
    mem_we = 1'b0;
    start  = 1'b0;
    step();
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_hart = 1'b0;
    cfg_delay = '0; cfg_period = '0; timeout = '0;
    mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    test_reset();
    test_single();
    test_two_harts();
    test_timeout();
    test_collision();
    test_reset_abort();
`ifdef DBG_SCHED_REPEAT_EN
    test_repeat();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
